// File: rtl/wb_pkg.sv
// Shared definitions for the writeback stage.
//   - writeback source select encodings (in_wb_sel)
//   - load funct3 encodings
//   - FSM state enum and the pending-load record held while data is outstanding
package wb_pkg;

   localparam logic [1:0] WB_ALU  = 2'b00;
   localparam logic [1:0] WB_LOAD = 2'b01;
   localparam logic [1:0] WB_PC4  = 2'b10;
   localparam logic [1:0] WB_IMM  = 2'b11;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   typedef enum logic {
      S_IDLE,
      S_WAIT_LOAD
   } state_t;

   // Everything needed to finish a load once its data shows up.
   typedef struct packed {
      logic [4:0] rd;
      logic       reg_write;
      logic [2:0] funct3;
      logic [1:0] offset;
   } pend_t;

endpackage

// File: rtl/writeback_stage_load_align.sv
// load_align: combinational load data alignment and legality check.
// Ports:
//   funct3  in  3  load type (LB/LH/LW/LBU/LHU)
//   offset  in  2  byte offset within the word (address bits [1:0])
//   rdata   in 32  word-aligned memory data
//   data    out 32 aligned, sign/zero-extended load result
//   legal   out 1  funct3 is a load type and the offset is naturally aligned
module load_align
   import wb_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  offset,
   input  logic [31:0] rdata,
   output logic [31:0] data,
   output logic        legal
);

   logic [31:0] shifted;

   always_comb begin
      // Bring the addressed byte/half down to bit 0.
      shifted = rdata >> {offset, 3'b000};
      data    = rdata;
      legal   = 1'b0;
      case (funct3)
         F3_LB: begin
            data  = {{24{shifted[7]}}, shifted[7:0]};
            legal = 1'b1;
         end
         F3_LBU: begin
            data  = {24'd0, shifted[7:0]};
            legal = 1'b1;
         end
         F3_LH: begin
            data  = {{16{shifted[15]}}, shifted[15:0]};
            legal = ~offset[0];
         end
         F3_LHU: begin
            data  = {16'd0, shifted[15:0]};
            legal = ~offset[0];
         end
         F3_LW: begin
            data  = rdata;
            legal = (offset == 2'b00);
         end
         default: begin
            data  = rdata;
            legal = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/writeback_stage.sv
// writeback_stage: final pipeline stage. Selects the writeback source, waits
// for multi-cycle load data, aligns loads and drives the register file write
// port one cycle after completion. Also counts retired instructions.
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   in_valid .. in_load_funct3    instruction from the MEM stage
//   mem_rdata_valid, mem_rdata    load data return
//   stall                         hold upstream (combinational)
//   do_reg_write, do_write_reg,
//   write_data                    register file write port (registered)
//   load_fault                    one-cycle pulse on misaligned/illegal load
//   instret                       retired-instruction counter (wraps)
module writeback_stage
   import wb_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   input  logic            in_reg_write,
   input  logic [4:0]      in_write_reg,
   input  logic [1:0]      in_wb_sel,
   input  logic [XLEN-1:0] in_alu_result,
   input  logic [XLEN-1:0] in_pc_plus4,
   input  logic [XLEN-1:0] in_imm,
   input  logic [2:0]      in_load_funct3,
   input  logic            mem_rdata_valid,
   input  logic [XLEN-1:0] mem_rdata,
   output logic            stall,
   output logic            do_reg_write,
   output logic [4:0]      do_write_reg,
   output logic [XLEN-1:0] write_data,
   output logic            load_fault,
   output logic [31:0]     instret
);

   state_t state, state_nxt;
   pend_t  pend, pend_nxt;

   logic [2:0]      al_f3;
   logic [1:0]      al_off;
   logic [XLEN-1:0] al_data;
   logic            al_legal;

   logic            stall_raw;
   logic            cpl, cpl_fault, cpl_rw;
   logic [4:0]      cpl_rd;
   logic [XLEN-1:0] cpl_data;

   // One aligner serves both the IDLE legality check (fresh inputs) and the
   // WAIT_LOAD data path (latched funct3/offset).
   assign al_f3  = (state == S_WAIT_LOAD) ? pend.funct3 : in_load_funct3;
   assign al_off = (state == S_WAIT_LOAD) ? pend.offset : in_alu_result[1:0];

   load_align u_align (
      .funct3 (al_f3),
      .offset (al_off),
      .rdata  (mem_rdata),
      .data   (al_data),
      .legal  (al_legal)
   );

   always_comb begin
      state_nxt = state;
      pend_nxt  = pend;
      stall_raw = 1'b0;
      cpl       = 1'b0;
      cpl_fault = 1'b0;
      cpl_rd    = in_write_reg;
      cpl_rw    = in_reg_write;
      cpl_data  = in_alu_result;
      case (state)
         S_IDLE: begin
            if (in_valid) begin
               case (in_wb_sel)
                  WB_ALU:  cpl_data = in_alu_result;
                  WB_PC4:  cpl_data = in_pc_plus4;
                  WB_IMM:  cpl_data = in_imm;
                  default: cpl_data = al_data;
               endcase
               if (in_wb_sel != WB_LOAD) begin
                  cpl = 1'b1;
               end else if (!al_legal) begin
                  cpl       = 1'b1;
                  cpl_fault = 1'b1;
               end else if (mem_rdata_valid) begin
                  cpl = 1'b1;
               end else begin
                  stall_raw          = 1'b1;
                  state_nxt          = S_WAIT_LOAD;
                  pend_nxt.rd        = in_write_reg;
                  pend_nxt.reg_write = in_reg_write;
                  pend_nxt.funct3    = in_load_funct3;
                  pend_nxt.offset    = in_alu_result[1:0];
               end
            end
         end
         S_WAIT_LOAD: begin
            cpl_rd   = pend.rd;
            cpl_rw   = pend.reg_write;
            cpl_data = al_data;
            if (mem_rdata_valid) begin
               cpl       = 1'b1;
               state_nxt = S_IDLE;
            end else begin
               stall_raw = 1'b1;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   assign stall = stall_raw & ~reset;

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= S_IDLE;
         pend         <= '0;
         do_reg_write <= 1'b0;
         do_write_reg <= 5'd0;
         write_data   <= '0;
         load_fault   <= 1'b0;
         instret      <= 32'd0;
      end else begin
         state        <= state_nxt;
         pend         <= pend_nxt;
         // x0 is hardwired zero: never raise the write enable for it.
         do_reg_write <= cpl & ~cpl_fault & cpl_rw & (cpl_rd != 5'd0);
         load_fault   <= cpl & cpl_fault;
         // Index/data hold across idle and fault cycles.
         if (cpl && !cpl_fault) begin
            do_write_reg <= cpl_rd;
            write_data   <= cpl_data;
            instret      <= instret + 32'd1;
         end
      end
   end

endmodule

// File: doc/writeback_stage.md
# writeback_stage

Final pipeline stage: latches the MEM-stage result, waits for load data from a possibly multi-cycle data memory, aligns and sign/zero-extends loads, selects the writeback source, and drives the register file's write port (`do_reg_write`, `do_write_reg`, `write_data`). It stalls upstream while a load is outstanding, reports misaligned or illegal loads, and keeps a 32-bit retired-instruction counter.

## Interface
Parameters:
- `XLEN`, 32, datapath width; only 32 is supported.

Ports:
- `clk` in 1: rising-edge clock. One clock domain.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: MEM stage presents an instruction this cycle.
- `in_reg_write` in 1: the instruction writes a destination register.
- `in_write_reg` in 5: destination register index.
- `in_wb_sel` in 2: writeback source: 00 ALU, 01 load, 10 PC+4, 11 immediate.
- `in_alu_result` in 32: ALU result; also the load address.
- `in_pc_plus4` in 32: link value.
- `in_imm` in 32: immediate (LUI).
- `in_load_funct3` in 3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- `mem_rdata_valid` in 1: load data valid this cycle.
- `mem_rdata` in 32: word-aligned load data.
- `stall` out 1: upstream must hold its outputs.
- `do_reg_write` out 1: register file write enable.
- `do_write_reg` out 5: register file write index.
- `write_data` out 32: register file write data.
- `load_fault` out 1: one-cycle pulse for a misaligned or illegal load.
- `instret` out 32: count of retired instructions.

## Operation
- FSM states: IDLE and WAIT_LOAD.
- IDLE with `in_valid`=1, `in_wb_sel`≠01:
  - Completes this cycle.
  - Data: 00→`in_alu_result`, 10→`in_pc_plus4`, 11→`in_imm`.
- IDLE with `in_valid`=1, `in_wb_sel`=01:
  - Checks legality from `in_load_funct3` and `in_alu_result[1:0]`.
  - Illegal or misaligned load: completes immediately as a fault. Illegal = funct3 011/110/111. Misaligned = LH/LHU at offset 1 or 3, or LW at offset ≠0.
  - Legal load with `mem_rdata_valid`=1: completes this cycle.
  - Legal load otherwise: latches rd, reg_write, funct3 and offset, then moves to WAIT_LOAD.
- WAIT_LOAD:
  - Ignores all `in_*` inputs.
  - Completes when `mem_rdata_valid`=1, then returns to IDLE.
- Load alignment:
  - Selected byte = `mem_rdata[8*off+7:8*off]`; selected half = `mem_rdata[8*off+15:8*off]`.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- On completion, registered at the next edge:
  - `do_reg_write` = reg_write & no fault & rd≠0. x0 is never written.
  - `do_write_reg` = rd; `write_data` = selected data.
- Fault completion: `load_fault` pulses for one cycle, no write, `instret` is not incremented.
- Non-fault completion: `instret` += 1, wrapping modulo 2^32.
- When no completion occurs, the next-cycle outputs are `do_reg_write`=0 and `load_fault`=0. `do_write_reg`/`write_data` hold their last values.

## Timing
- Reset values: state IDLE, `do_reg_write` 0, `do_write_reg` 0, `write_data` 0, `load_fault` 0, `instret` 0.
- `stall` is combinational:
  - 1 in WAIT_LOAD.
  - 1 in IDLE when `in_valid` & `in_wb_sel`=01 & legal & !`mem_rdata_valid`.
  - 0 in the completing cycle.
  - 0 during reset.
- Latency:
  - Non-load: write outputs valid one cycle after `in_valid`; the register file commits on the following edge.
  - Load: outputs valid one cycle after the cycle `mem_rdata_valid`=1 is sampled.
- `mem_rdata_valid` asserted in IDLE without a legal load is ignored.
- Reset while in WAIT_LOAD:
  - Pending load is discarded; return to IDLE.
  - No write, no fault, `instret`=0.
  - Data arriving during reset is dropped.
- Back-to-back non-loads: one completion per cycle, full throughput.

## Structure
- Shared package `wb_pkg`: `in_wb_sel` encodings (WB_ALU, WB_LOAD, WB_PC4, WB_IMM), funct3 load constants, state enum (S_IDLE, S_WAIT_LOAD).
- One combinational sub-module, `load_align`: inputs funct3, offset and rdata; outputs 32-bit aligned data and a `legal` flag. The same check serves the IDLE legality test and WAIT_LOAD alignment.
- `writeback_stage` holds the FSM, pending-load registers, output registers and `instret`.

## Test plan
- Reset, then ALU write:
  - Stimulus: `in_valid`=1, wb_sel=00, rd=5, alu=0x1234.
  - Required: next cycle `do_reg_write`=1, `do_write_reg`=5, `write_data`=0x1234, `instret`=1.
- x0 suppression:
  - Stimulus: rd=0, wb_sel=10, pc4=0x40.
  - Required: `do_reg_write`=0, `instret`=1.
- Delayed LB:
  - Stimulus: LB, addr 0x...3, rd=7; `mem_rdata_valid` rises 3 cycles later with `mem_rdata`=0x80FFFFFF.
  - Required: `stall`=1 for 3 cycles, then `write_data`=0xFFFFFF80, `do_write_reg`=7.
- LHU/LW:
  - LHU at offset 2 with `mem_rdata`=0xBEEF0000 → `write_data`=0x0000BEEF.
  - LW at offset 2 → `load_fault` pulse, no write, `instret` unchanged, no stall.
- Reset during WAIT_LOAD:
  - Stimulus: assert `reset` while waiting; then `mem_rdata_valid`=1.
  - Required: no write, state IDLE, `stall`=0.
- Counter wrap:
  - Stimulus: preload `instret`=0xFFFFFFFF via 2^32−1 completions or force, then retire one instruction.
  - Required: `instret`=0.
